// File: rtl/hamming_code_decoder.sv
// hamming_code_decoder
//   Registered Hamming(7,4) single-error-correcting decoder.
//   A 7-bit codeword is accepted on any rising edge with in_valid high. The
//   3-bit syndrome is formed from it and, unless detect-only mode is selected,
//   the bit it points to is flipped before the data bits are extracted. All
//   results appear one clock later.
//
// Handshake: in_valid/out_valid only, no backpressure. An input is accepted
//   on every rising edge where in_valid=1. out_valid is high exactly in the
//   cycle after an acceptance. Results (y/syndrome/err) change only on an
//   acceptance and otherwise hold their last value.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   x/select sampled when high
//   select     0 = correct the flagged bit, 1 = detect only
//   x[6:0]     codeword, x[i] is Hamming position i+1
//              (x0=p1 x1=p2 x2=d1 x3=p4 x4=d2 x5=d3 x6=d4)
//   y[3:0]     decoded data {d4,d3,d2,d1}
//   syndrome   {s4,s2,s1}; nonzero = erroneous position 1..7
//   err        1 when syndrome is nonzero
//   out_valid  high one cycle after an accepted input
module hamming_code_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       select,
  input  logic [6:0] x,
  output logic [3:0] y,
  output logic [2:0] syndrome,
  output logic       err,
  output logic       out_valid
);

  logic [2:0] syn_c;
  logic [6:0] fixed_c;
  logic [3:0] data_c;

  // Each syndrome bit covers the positions whose index has that bit set.
  always_comb begin
    syn_c[0] = x[0] ^ x[2] ^ x[4] ^ x[6];
    syn_c[1] = x[1] ^ x[2] ^ x[5] ^ x[6];
    syn_c[2] = x[3] ^ x[4] ^ x[5] ^ x[6];
  end

  // Flip position i+1 when the syndrome names it. A zero syndrome matches no
  // position, so a clean word passes unchanged without a separate check.
  always_comb begin
    fixed_c = x;
    for (int i = 0; i < 7; i++) begin
      if (syn_c == 3'(i + 1)) begin
        fixed_c[i] = ~x[i];
      end
    end
  end

  // Detect-only mode takes the raw data positions; a parity-position
  // correction never touches data bits, so both paths agree in that case.
  always_comb begin
    data_c = 4'd0;
    if (select) begin
      data_c = {x[6], x[5], x[4], x[2]};
    end else begin
      data_c = {fixed_c[6], fixed_c[5], fixed_c[4], fixed_c[2]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y         <= 4'd0;
      syndrome  <= 3'd0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y        <= data_c;
        syndrome <= syn_c;
        err      <= |syn_c;
      end
    end
  end

endmodule

// File: tb/tb_hamming_code_decoder.sv
module tb_hamming_code_decoder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       select;
  logic [6:0] x;
  logic [3:0] y;
  logic [2:0] syndrome;
  logic       err;
  logic       out_valid;

  int n_vec;
  int n_fail;
  int n_cmp;

  // Expected {y, syndrome, err}
  logic [7:0] exp_q[$];
  logic [7:0] last_exp;

  hamming_code_decoder dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .select(select),
    .x(x),
    .y(y),
    .syndrome(syndrome),
    .err(err),
    .out_valid(out_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Syndrome = XOR of the 1-based positions of all set bits.
  function automatic int pos_xor(input logic [6:0] cw);
    int s;
    s = 0;
    for (int i = 0; i < 7; i++) begin
      if (cw[i]) s = s ^ (i + 1);
    end
    return s;
  endfunction

  function automatic logic [7:0] model(input logic [6:0] cw, input logic sel);
    int s;
    logic [6:0] c;
    logic [2:0] s3;
    s  = pos_xor(cw);
    c  = cw;
    s3 = s[2:0];
    if (!sel && s != 0) c[s-1] = ~c[s-1];
    return {c[6], c[5], c[4], c[2], s3, (s != 0)};
  endfunction

  // Put data in positions 3,5,6,7, then choose parity positions 1,2,4 so
  // that the overall position-XOR becomes zero.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] cw;
    int s;
    cw    = 7'd0;
    cw[2] = d[0];
    cw[4] = d[1];
    cw[5] = d[2];
    cw[6] = d[3];
    s     = pos_xor(cw);
    cw[0] = s[0];
    cw[1] = s[1];
    cw[3] = s[2];
    return cw;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [6:0] cw, input logic sel);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    select   = sel;
    x        = cw;
    exp_q.push_back(model(cw, sel));
    n_vec++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      select   = 1'($urandom_range(0, 1));
      x        = 7'($urandom);
    end
  endtask

  task automatic check_direct(input string name, input logic [8:0] act, input logic [8:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    last_exp = 8'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_exp = 8'd0;
        n_cmp++;
        if ({y, syndrome, err, out_valid} !== 9'd0) begin
          n_fail++;
          $display("FAIL reset_hold: got %b, expected 0", {y, syndrome, err, out_valid});
        end
      end else if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out: out_valid with no pending input, got %b", {y, syndrome, err});
        end else begin
          last_exp = exp_q.pop_front();
          if ({y, syndrome, err} !== last_exp) begin
            n_fail++;
            $display("FAIL result: got y=%b syn=%0d err=%b, expected y=%b syn=%0d err=%b",
                     y, syndrome, err, last_exp[7:4], last_exp[3:1], last_exp[0]);
          end
        end
      end else begin
        n_cmp++;
        if ({y, syndrome, err} !== last_exp || out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL hold: got %b ov=%b, expected %b ov=0", {y, syndrome, err}, out_valid, last_exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] cw;
    logic [6:0] e;
    int wait_cnt;
    n_vec = 0;
    n_fail = 0;
    n_cmp = 0;
    in_valid = 1'b0;
    select = 1'b0;
    x = 7'd0;
    rst = 1'b1;
    #1;
    check_direct("power_on_reset", {y, syndrome, err, out_valid}, 9'd0);
    idle(3);
    rst = 1'b0;
    idle(2);

    // Directed vectors from the worked examples.
    drive(7'b1010101, 1'b0);
    drive(7'b1000101, 1'b0);
    drive(7'b1000101, 1'b1);
    drive(7'b1010100, 1'b0);
    idle(1);
    check_direct("clean_vs_model", {1'b0, model(7'b1010101, 1'b0)}, {1'b0, 4'b1011, 3'd0, 1'b0});
    check_direct("detect_vs_model", {1'b0, model(7'b1000101, 1'b1)}, {1'b0, 4'b1001, 3'd5, 1'b1});
    idle(2);

    // Exhaustive streaming: every data value, clean and each single-bit error.
    for (int d = 0; d < 16; d++) begin
      for (int p = 0; p < 8; p++) begin
        cw = encode(4'(d));
        if (p > 0) cw[p-1] = ~cw[p-1];
        drive(cw, 1'b0);
      end
    end
    idle(1);

    // Same set in detect-only mode, with random single-cycle gaps.
    for (int d = 0; d < 16; d++) begin
      for (int p = 0; p < 8; p++) begin
        cw = encode(4'(d));
        if (p > 0) cw[p-1] = ~cw[p-1];
        drive(cw, 1'b1);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end

    // Random codewords with 0..2 errors and random select / gaps.
    for (int n = 0; n < 200; n++) begin
      cw = encode(4'($urandom));
      e = 7'd0;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) e[$urandom_range(0, 6)] = 1'b1;
      drive(cw ^ e, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 2)));
    end

    // Reset mid-stream: pending result is discarded, outputs clear at once.
    drive(encode(4'hA) ^ 7'b0010000, 1'b0);
    drive(encode(4'h5), 1'b1);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    check_direct("async_reset", {y, syndrome, err, out_valid}, 9'd0);
    idle(3);
    rst = 1'b0;
    idle(3);
    drive(7'b1000101, 1'b0);
    drive(7'b1111111, 1'b0);
    idle(3);

    // Drain with a bounded wait.
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results never appeared, expected 0", exp_q.size());
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
